// File: rtl/icache_pkg.sv
// Shared sizes, FSM state type and word-select helper for the instruction cache.
package icache_pkg;

    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 4;
    localparam int BLOCK_W    = 128;
    localparam int LINES      = 8;
    localparam int ADDR_W     = TAG_W + INDEX_W + OFFSET_W;
    localparam int WORD_W     = 32;
    localparam int WORD_SEL_W = OFFSET_W - 2;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        UPDATE
    } state_t;

    function automatic logic [WORD_W-1:0] select_word(
        input logic [BLOCK_W-1:0]    blk,
        input logic [WORD_SEL_W-1:0] word
    );
        return blk[WORD_W*word +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_if.sv
// CPU-side fetch signals and memory-side block handshake of the instruction cache.
interface icache_if;
    import icache_pkg::*;

    logic                  read;
    logic [ADDR_W-1:0]     address;
    logic [WORD_W-1:0]     instruction;
    logic                  busywait;
    logic                  mem_read;
    logic [MEM_ADDR_W-1:0] mem_address;
    logic [BLOCK_W-1:0]    mem_readinst;
    logic                  mem_busywait;

    // The cache itself.
    modport slave (
        input  read,
        input  address,
        output instruction,
        output busywait,
        output mem_read,
        output mem_address,
        input  mem_readinst,
        input  mem_busywait
    );

    // The surrounding CPU and instruction memory.
    modport master (
        output read,
        output address,
        input  instruction,
        input  busywait,
        input  mem_read,
        input  mem_address,
        output mem_readinst,
        output mem_busywait
    );

endinterface

// File: rtl/icache_store.sv
// Valid/tag/data line storage: combinational read port, clocked write port, valid clear on reset.
module icache_store
    import icache_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [BLOCK_W-1:0] wr_data
);

    logic [LINES-1:0]   valid_reg;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [BLOCK_W-1:0] data_mem [LINES];
    logic [LINES-1:0]   line_wr;

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line_sel
            assign line_wr[gi] = wr_en && (wr_index == INDEX_W'(gi));
        end
    endgenerate

    // Reset wins over a fill landing on the same edge, so no line can come out of reset valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_reg | line_wr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_reg[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: hit compare plus the IDLE/MEM_READ/UPDATE miss FSM.
module icache
    import icache_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    icache_if.slave bus
);

    logic [TAG_W-1:0]      tag;
    logic [INDEX_W-1:0]    index;
    logic [WORD_SEL_W-1:0] word;

    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [BLOCK_W-1:0]    line_data;
    logic                  hit;

    state_t                state_reg, state_next;
    logic [MEM_ADDR_W-1:0] miss_addr_reg, miss_addr_next;
    logic                  busywait_next;
    logic                  mem_read_next;
    logic                  fill;

    assign tag   = bus.address[ADDR_W-1 -: TAG_W];
    assign index = bus.address[OFFSET_W +: INDEX_W];
    assign word  = bus.address[2 +: WORD_SEL_W];

    icache_store u_store (
        .clock    (clock),
        .reset    (reset),
        .rd_index (index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (fill),
        .wr_index (miss_addr_reg[INDEX_W-1:0]),
        .wr_tag   (miss_addr_reg[MEM_ADDR_W-1 -: TAG_W]),
        .wr_data  (bus.mem_readinst)
    );

    assign hit = line_valid && (line_tag == tag);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= IDLE;
            miss_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            miss_addr_reg <= miss_addr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        miss_addr_next = miss_addr_reg;
        busywait_next  = 1'b1;
        mem_read_next  = 1'b0;
        fill           = 1'b0;
        case (state_reg)
            IDLE: begin
                busywait_next = bus.read && !hit;
                if (bus.read && !hit) begin
                    miss_addr_next = {tag, index};
                    state_next     = MEM_READ;
                end
            end
            MEM_READ: begin
                mem_read_next = 1'b1;
                if (!bus.mem_busywait) begin
                    fill       = 1'b1;
                    state_next = UPDATE;
                end
            end
            // One idle-handshake cycle so memory sees mem_read low before any new request.
            UPDATE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busywait    = busywait_next;
    assign bus.mem_read    = mem_read_next;
    assign bus.mem_address = miss_addr_reg;
    assign bus.instruction = select_word(line_data, word);

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache with a fixed-latency instruction memory model.
module tb_icache;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    icache_if bus ();

    icache dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Memory holds mem_busywait high for LAT edges of each request, then presents the block.
    localparam int LAT = 2;
    localparam int EXP_STALL = LAT + 3;
    int lat_cnt = 0;

    always @(posedge clock) begin
        if (bus.mem_read === 1'b1) lat_cnt <= lat_cnt + 1;
        else                       lat_cnt <= 0;
    end

    function automatic logic [127:0] mem_block(input logic [5:0] b);
        logic [127:0] blk;
        for (int w = 0; w < 4; w++)
            blk[32*w +: 32] = 32'hA000_0000 | ({26'd0, b} << 8) | 32'(w);
        if (b == 6'd0) blk = {32'h1122_3344, 32'h0206_0405, 32'h0005_0023, 32'h0004_0019};
        if (b == 6'd1) blk[31:0] = 32'h0301_0104;
        return blk;
    endfunction

    assign bus.mem_busywait = (bus.mem_read === 1'b1) && (lat_cnt < LAT);
    assign bus.mem_readinst = mem_block(bus.mem_address);

    int passed = 0;
    int total  = 0;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Steps edges until busywait drops (bounded), noting the first mem_read address seen.
    task automatic wait_fill(output int edges, output logic seen_read, output logic [5:0] seen_addr);
        edges     = 0;
        seen_read = 1'b0;
        seen_addr = 6'd0;
        while (bus.busywait === 1'b1 && edges < 50) begin
            if (bus.mem_read === 1'b1 && !seen_read) begin
                seen_read = 1'b1;
                seen_addr = bus.mem_address;
            end
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.read = 1'b0;
        bus.address = 10'h000;
        tick();
        tick();
        reset = 1'b1;
        #1;
        $display("txn reset: busywait=%b mem_read=%b mem_address=%0d", bus.busywait, bus.mem_read, bus.mem_address);
        total++; if (bus.busywait !== 1'b0) $display("FAIL reset_busywait got %b want 0", bus.busywait); else passed++;
        total++; if (bus.mem_read !== 1'b0) $display("FAIL reset_mem_read got %b want 0", bus.mem_read); else passed++;
        total++; if (bus.mem_address !== 6'd0) $display("FAIL reset_mem_address got %0d want 0", bus.mem_address); else passed++;
    endtask

    task automatic test_cold_miss();
        int e; logic sr; logic [5:0] sa;
        bus.read = 1'b1;
        bus.address = 10'h000;
        #1;
        total++; if (bus.busywait !== 1'b1) $display("FAIL cold_busywait got %b want 1", bus.busywait); else passed++;
        total++; if (bus.mem_read !== 1'b0) $display("FAIL cold_mem_read_cycle0 got %b want 0", bus.mem_read); else passed++;
        wait_fill(e, sr, sa);
        $display("txn cold miss 0x000: stall=%0d mem_address=%0d instruction=%h", e, sa, bus.instruction);
        total++; if (e !== EXP_STALL) $display("FAIL cold_stall got %0d want %0d", e, EXP_STALL); else passed++;
        total++; if (sr !== 1'b1 || sa !== 6'd0) $display("FAIL cold_mem_address got %b/%0d want 1/0", sr, sa); else passed++;
        total++; if (bus.instruction !== 32'h0004_0019) $display("FAIL cold_instruction got %h want 00040019", bus.instruction); else passed++;
        total++; if (bus.mem_read !== 1'b0) $display("FAIL cold_mem_read_after got %b want 0", bus.mem_read); else passed++;
    endtask

    task automatic test_hit_same_block();
        bus.address = 10'h004;
        #1;
        $display("txn hit 0x004: busywait=%b instruction=%h", bus.busywait, bus.instruction);
        total++; if (bus.busywait !== 1'b0) $display("FAIL hit_busywait got %b want 0", bus.busywait); else passed++;
        total++; if (bus.instruction !== 32'h0005_0023) $display("FAIL hit_instruction got %h want 00050023", bus.instruction); else passed++;
        tick();
        total++; if (bus.mem_read !== 1'b0) $display("FAIL hit_mem_read got %b want 0", bus.mem_read); else passed++;
        total++; if (bus.busywait !== 1'b0) $display("FAIL hit_busywait_next got %b want 0", bus.busywait); else passed++;
    endtask

    task automatic test_second_block();
        int e; logic sr; logic [5:0] sa;
        bus.address = 10'h010;
        #1;
        total++; if (bus.busywait !== 1'b1) $display("FAIL second_busywait got %b want 1", bus.busywait); else passed++;
        wait_fill(e, sr, sa);
        $display("txn miss 0x010: stall=%0d mem_address=%0d instruction=%h", e, sa, bus.instruction);
        total++; if (e !== EXP_STALL) $display("FAIL second_stall got %0d want %0d", e, EXP_STALL); else passed++;
        total++; if (sr !== 1'b1 || sa !== 6'd1) $display("FAIL second_mem_address got %b/%0d want 1/1", sr, sa); else passed++;
        total++; if (bus.instruction !== 32'h0301_0104) $display("FAIL second_instruction got %h want 03010104", bus.instruction); else passed++;
        bus.address = 10'h000;
        #1;
        total++; if (bus.busywait !== 1'b0) $display("FAIL second_line0_kept got %b want 0", bus.busywait); else passed++;
    endtask

    task automatic test_conflict();
        int e; logic sr; logic [5:0] sa;
        bus.address = 10'h080;
        #1;
        total++; if (bus.busywait !== 1'b1) $display("FAIL evict_busywait got %b want 1", bus.busywait); else passed++;
        wait_fill(e, sr, sa);
        $display("txn miss 0x080: stall=%0d mem_address=%0d instruction=%h", e, sa, bus.instruction);
        total++; if (sr !== 1'b1 || sa !== 6'd8) $display("FAIL evict_mem_address got %b/%0d want 1/8", sr, sa); else passed++;
        total++; if (bus.instruction !== 32'hA000_0800) $display("FAIL evict_instruction got %h want a0000800", bus.instruction); else passed++;
        bus.address = 10'h000;
        #1;
        total++; if (bus.busywait !== 1'b1) $display("FAIL refill_busywait got %b want 1", bus.busywait); else passed++;
        wait_fill(e, sr, sa);
        $display("txn miss 0x000: stall=%0d mem_address=%0d instruction=%h", e, sa, bus.instruction);
        total++; if (sr !== 1'b1 || sa !== 6'd0) $display("FAIL refill_mem_address got %b/%0d want 1/0", sr, sa); else passed++;
        bus.address = 10'h008;
        #1;
        total++; if (bus.busywait !== 1'b0) $display("FAIL refill_hit_busywait got %b want 0", bus.busywait); else passed++;
        total++; if (bus.instruction !== 32'h0206_0405) $display("FAIL refill_hit_instruction got %h want 02060405", bus.instruction); else passed++;
    endtask

    task automatic test_reset_mid_fill();
        int e; int n; logic sr; logic [5:0] sa;
        bus.address = 10'h020;
        #1;
        total++; if (bus.busywait !== 1'b1) $display("FAIL midreset_miss got %b want 1", bus.busywait); else passed++;
        tick();
        total++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 6'd2) $display("FAIL midreset_mem_read got %b/%0d want 1/2", bus.mem_read, bus.mem_address); else passed++;
        reset = 1'b0;
        bus.read = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        $display("txn reset in MEM_READ: mem_read=%b busywait=%b", bus.mem_read, bus.busywait);
        total++; if (bus.mem_read !== 1'b0) $display("FAIL midreset_mem_read_drop got %b want 0", bus.mem_read); else passed++;
        total++; if (bus.busywait !== 1'b0) $display("FAIL midreset_busywait got %b want 0", bus.busywait); else passed++;
        tick();
        tick();
        bus.read = 1'b1;
        bus.address = 10'h000;
        #1;
        total++; if (bus.busywait !== 1'b1) $display("FAIL midreset_remiss got %b want 1", bus.busywait); else passed++;
        wait_fill(e, sr, sa);
        total++; if (bus.instruction !== 32'h0004_0019) $display("FAIL midreset_refill got %h want 00040019", bus.instruction); else passed++;

        // Reset landing on the very edge that would write the line.
        bus.address = 10'h020;
        #1;
        tick();
        n = 0;
        while (bus.mem_busywait !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        total++; if (n >= 20 || bus.mem_read !== 1'b1) $display("FAIL fillreset_reach got %0d/%b want <20/1", n, bus.mem_read); else passed++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        $display("txn reset on fill edge: mem_read=%b busywait=%b", bus.mem_read, bus.busywait);
        total++; if (bus.mem_read !== 1'b0) $display("FAIL fillreset_mem_read got %b want 0", bus.mem_read); else passed++;
        total++; if (bus.busywait !== 1'b1) $display("FAIL fillreset_no_write got %b want 1", bus.busywait); else passed++;
        wait_fill(e, sr, sa);
        total++; if (e !== EXP_STALL) $display("FAIL fillreset_stall got %0d want %0d", e, EXP_STALL); else passed++;
        total++; if (bus.instruction !== 32'hA000_0200) $display("FAIL fillreset_instruction got %h want a0000200", bus.instruction); else passed++;
    endtask

    task automatic test_idle();
        bus.read = 1'b0;
        bus.address = 10'h3FC;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (bus.busywait !== 1'b0) $display("FAIL idle_busywait[%0d] got %b want 0", i, bus.busywait); else passed++;
            total++; if (bus.mem_read !== 1'b0) $display("FAIL idle_mem_read[%0d] got %b want 0", i, bus.mem_read); else passed++;
            total++; if (bus.mem_address !== 6'd2) $display("FAIL idle_mem_address[%0d] got %0d want 2", i, bus.mem_address); else passed++;
        end
        bus.read = 1'b1;
        bus.address = 10'h020;
        #1;
        $display("txn idle 10 cycles then hit 0x020: busywait=%b instruction=%h", bus.busywait, bus.instruction);
        total++; if (bus.busywait !== 1'b0) $display("FAIL idle_then_hit got %b want 0", bus.busywait); else passed++;
        total++; if (bus.instruction !== 32'hA000_0200) $display("FAIL idle_then_instr got %h want a0000200", bus.instruction); else passed++;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_same_block();
        test_second_block();
        test_conflict();
        test_reset_mid_fill();
        test_idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
